lif_array: RTL and testbench

LIF_ARRAY -- requirements
Module: lif_array

---
 rtl/lif_array.sv | 155 +++++++++++++++
 tb/tb_lif_array.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_array.sv
// lif_array: time-multiplexed array of leaky integrate-and-fire neurons.
// A tick divider starts a sweep that updates one channel per clock.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en           tick divider run enable
//   clr          sync clear of neuron state and overrun
//   thresh       firing threshold, latched at sweep start
//   i_in         per-channel unsigned input current, ch k at [k*W +: W]
//   spike        per-channel spike flag, held until next processing edge
//   busy         high while a sweep is running
//   sweep_done   one-cycle pulse after the last channel update
//   heartbeat    toggles on every tick
//   overrun      sticky, set when a tick arrives during a sweep
module lif_array #(
    parameter int NCH       = 4,
    parameter int W         = 8,
    parameter int PW        = 12,
    parameter int LEAK_SH   = 3,
    parameter int REF_TICKS = 2,
    parameter int TICK_DIV  = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [PW-1:0]     thresh,
    input  logic [NCH*W-1:0]  i_in,
    output logic [NCH-1:0]    spike,
    output logic              busy,
    output logic              sweep_done,
    output logic              heartbeat,
    output logic              overrun
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t          state_q;
    logic [DW-1:0]   div_q;
    logic            hb_q;
    logic [IW-1:0]   idx_q;
    logic [PW-1:0]   thr_q;
    logic [PW-1:0]   u_q   [NCH];
    logic [3:0]      ref_q [NCH];
    logic [NCH-1:0]  spike_q;
    logic            done_q;
    logic            ovr_q;

    logic            tick;
    logic [PW-1:0]   u_cur;
    logic [3:0]      ref_cur;
    logic [W-1:0]    i_cur;
    logic [PW:0]     leak;
    logic [PW:0]     sum;
    logic [PW-1:0]   u_d;
    logic            fire;

    assign tick = en && (div_q == DIV_LAST);

    // Datapath for the channel selected by idx_q.
    // U - (U >> LEAK_SH) never underflows, so only the top end saturates.
    always_comb begin
        u_cur   = u_q[idx_q];
        ref_cur = ref_q[idx_q];
        i_cur   = i_in[int'(idx_q)*W +: W];
        leak    = '0;
        if (LEAK_SH != 0)
            leak = {1'b0, u_cur} >> LEAK_SH;
        sum  = {1'b0, u_cur} - leak + {{(PW+1-W){1'b0}}, i_cur};
        u_d  = sum[PW] ? {PW{1'b1}} : sum[PW-1:0];
        fire = (u_d >= thr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            hb_q    <= 1'b0;
            state_q <= IDLE;
            idx_q   <= '0;
            thr_q   <= '0;
            spike_q <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                u_q[k]   <= '0;
                ref_q[k] <= '0;
            end
        end else begin
            // Divider and heartbeat keep running through clr.
            if (en)
                div_q <= tick ? '0 : div_q + 1'b1;
            if (tick)
                hb_q <= ~hb_q;
            done_q <= 1'b0;

            if (clr) begin
                state_q <= IDLE;
                idx_q   <= '0;
                spike_q <= '0;
                ovr_q   <= 1'b0;
                for (int k = 0; k < NCH; k++) begin
                    u_q[k]   <= '0;
                    ref_q[k] <= '0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (tick) begin
                            state_q <= SWEEP;
                            idx_q   <= '0;
                            thr_q   <= thresh;
                        end
                    end
                    SWEEP: begin
                        // A tick mid-sweep is dropped, the sweep goes on.
                        if (tick)
                            ovr_q <= 1'b1;
                        if (ref_cur != 4'd0) begin
                            ref_q[idx_q]   <= ref_cur - 4'd1;
                            u_q[idx_q]     <= '0;
                            spike_q[idx_q] <= 1'b0;
                        end else if (fire) begin
                            ref_q[idx_q]   <= 4'(REF_TICKS);
                            u_q[idx_q]     <= '0;
                            spike_q[idx_q] <= 1'b1;
                        end else begin
                            u_q[idx_q]     <= u_d;
                            spike_q[idx_q] <= 1'b0;
                        end
                        if (idx_q == IDX_LAST) begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign spike      = spike_q;
    assign busy       = (state_q == SWEEP);
    assign sweep_done = done_q;
    assign heartbeat  = hb_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_lif_array.sv
// tb_lif_array: directed checks of lif_array.
// Three instances: default leak, no leak (saturation), short tick period.
module tb_lif_array;

    logic        clk;
    logic        rst_n;

    logic        en_m, clr_m, busy_m, done_m, hb_m, ovr_m;
    logic [11:0] thresh_m;
    logic [31:0] i_in_m;
    logic [3:0]  spike_m;

    logic        en_s, clr_s, busy_s, done_s, hb_s, ovr_s;
    logic [11:0] thresh_s;
    logic [31:0] i_in_s;
    logic [3:0]  spike_s;

    logic        en_o, clr_o, busy_o, done_o, hb_o, ovr_o;
    logic [11:0] thresh_o;
    logic [31:0] i_in_o;
    logic [3:0]  spike_o;

    int total;
    int bad;

    lif_array #(.TICK_DIV(16)) dut_m (
        .clk(clk), .rst_n(rst_n), .en(en_m), .clr(clr_m),
        .thresh(thresh_m), .i_in(i_in_m), .spike(spike_m),
        .busy(busy_m), .sweep_done(done_m), .heartbeat(hb_m),
        .overrun(ovr_m)
    );

    lif_array #(.LEAK_SH(0), .TICK_DIV(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en_s), .clr(clr_s),
        .thresh(thresh_s), .i_in(i_in_s), .spike(spike_s),
        .busy(busy_s), .sweep_done(done_s), .heartbeat(hb_s),
        .overrun(ovr_s)
    );

    lif_array #(.TICK_DIV(3)) dut_o (
        .clk(clk), .rst_n(rst_n), .en(en_o), .clr(clr_o),
        .thresh(thresh_o), .i_in(i_in_o), .spike(spike_o),
        .busy(busy_o), .sweep_done(done_o), .heartbeat(hb_o),
        .overrun(ovr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for busy of the chosen instance (0=m, 1=s, 2=o).
    task automatic wait_busy(input int which, output int n);
        logic b;
        b = 1'b0;
        n = 0;
        for (int i = 0; i < 64 && !b; i++) begin
            step();
            n++;
            if (which == 0)      b = busy_m;
            else if (which == 1) b = busy_s;
            else                 b = busy_o;
        end
        if (!b)
            check("wait_busy", 32'(b), 1);
    endtask

    int   n;
    logic hb0;
    logic seen;
    int   exp_sp0 [6] = '{0, 0, 1, 0, 0, 0};
    int   exp_u0  [6] = '{40, 75, 0, 0, 0, 40};
    int   exp_sp1 [6] = '{1, 0, 0, 1, 0, 0};

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en_m = 0; clr_m = 0; thresh_m = 12'd100;
        i_in_m = {8'd200, 8'd0, 8'd255, 8'd40};
        en_s = 0; clr_s = 0; thresh_s = 12'd4095;
        i_in_s = {8'd0, 8'd0, 8'd0, 8'd255};
        en_o = 0; clr_o = 0; thresh_o = 12'd100;
        i_in_o = {8'd200, 8'd0, 8'd255, 8'd40};

        repeat (3) step();
        check("rst_spike", 32'(spike_m), 0);
        check("rst_busy", 32'(busy_m), 0);
        check("rst_done", 32'(done_m), 0);
        check("rst_hb", 32'(hb_m), 0);
        check("rst_ovr", 32'(ovr_m), 0);

        @(negedge clk);
        rst_n = 1'b1;
        en_m  = 1'b1;

        // Leak/refractory sequence plus sweep timing.
        for (int s = 0; s < 6; s++) begin
            hb0 = hb_m;
            wait_busy(0, n);
            check("sw_hb", 32'(hb_m), 32'(!hb0));
            if (s == 0) begin
                check("e0_spike", 32'(spike_m), 0);
                step();
                check("e1_busy", 32'(busy_m), 1);
                check("e1_u0", 32'(dut_m.u_q[0]), 40);
                check("e1_sp1", 32'(spike_m[1]), 0);
                step();
                check("e2_sp1", 32'(spike_m[1]), 1);
                check("e2_busy", 32'(busy_m), 1);
                step();
                check("e3_busy", 32'(busy_m), 1);
                check("e3_sp3", 32'(spike_m[3]), 0);
                check("e3_done", 32'(done_m), 0);
                step();
                check("e4_sp3", 32'(spike_m[3]), 1);
            end else begin
                repeat (4) step();
            end
            check("sw_done", 32'(done_m), 1);
            check("sw_busy", 32'(busy_m), 0);
            check("sw_sp0", 32'(spike_m[0]), 32'(exp_sp0[s]));
            check("sw_u0", 32'(dut_m.u_q[0]), 32'(exp_u0[s]));
            check("sw_sp1", 32'(spike_m[1]), 32'(exp_sp1[s]));
            if (s == 0) begin
                step();
                check("e5_done", 32'(done_m), 0);
            end
        end

        // Divider hold: en low for 20 cycles, then resume from 4.
        en_m = 1'b0;
        hb0  = hb_m;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (busy_m) seen = 1'b1;
        end
        check("en0_busy", 32'(seen), 0);
        check("en0_hb", 32'(hb_m), 32'(hb0));
        en_m = 1'b1;
        wait_busy(0, n);
        check("resume_n", 32'(n), 12);

        // Clear at E2 of sweep 7.
        step();
        check("s7_u0", 32'(dut_m.u_q[0]), 75);
        clr_m = 1'b1;
        step();
        clr_m = 1'b0;
        check("clr_busy", 32'(busy_m), 0);
        check("clr_spike", 32'(spike_m), 0);
        check("clr_u0", 32'(dut_m.u_q[0]), 0);
        check("clr_ovr", 32'(ovr_m), 0);
        step();
        check("clr_idle", 32'(busy_m), 0);

        // Zero threshold fires every non-refractory channel.
        thresh_m = 12'd0;
        wait_busy(0, n);
        step();
        check("t0_sp0", 32'(spike_m[0]), 1);
        step();
        step();
        check("t0_sp2", 32'(spike_m[2]), 1);
        step();
        check("t0_all", 32'(spike_m), 15);
        thresh_m = 12'd100;

        // Clear on the tick edge starts no sweep.
        repeat (11) step();
        hb0   = hb_m;
        clr_m = 1'b1;
        step();
        clr_m = 1'b0;
        check("ct_busy", 32'(busy_m), 0);
        check("ct_hb", 32'(hb_m), 32'(!hb0));
        step();
        check("ct_busy2", 32'(busy_m), 0);

        // Overrun with a 3-clock tick period.
        hb0  = hb_o;
        en_o = 1'b1;
        wait_busy(2, n);
        check("ov_hb0", 32'(hb_o), 32'(!hb0));
        check("ov_pre", 32'(ovr_o), 0);
        repeat (3) step();
        check("ov_set", 32'(ovr_o), 1);
        check("ov_busy", 32'(busy_o), 1);
        check("ov_hb", 32'(hb_o), 32'(hb0));
        step();
        check("ov_done", 32'(done_o), 1);
        check("ov_idle", 32'(busy_o), 0);
        check("ov_spike", 32'(spike_o), 10);
        check("ov_sticky", 32'(ovr_o), 1);
        step();
        step();
        check("ov_next", 32'(busy_o), 1);
        step();
        clr_o = 1'b1;
        step();
        clr_o = 1'b0;
        en_o  = 1'b0;
        check("ovc_ovr", 32'(ovr_o), 0);
        check("ovc_busy", 32'(busy_o), 0);
        check("ovc_spike", 32'(spike_o), 0);

        // Saturation without leak.
        en_s = 1'b1;
        for (int s = 1; s <= 17; s++) begin
            wait_busy(1, n);
            repeat (4) step();
            if (s == 16) begin
                check("sat16_sp", 32'(spike_s[0]), 0);
                check("sat16_u", 32'(dut_s.u_q[0]), 4080);
            end
            if (s == 17) begin
                check("sat17_sp", 32'(spike_s[0]), 1);
                check("sat17_u", 32'(dut_s.u_q[0]), 0);
            end
        end
        en_s = 1'b0;

        // Async reset mid-sweep, then a fresh sweep.
        wait_busy(0, n);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy_m), 0);
        check("ar_spike", 32'(spike_m), 0);
        check("ar_hb", 32'(hb_m), 0);
        check("ar_done", 32'(done_m), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_busy(0, n);
        check("ar_n", 32'(n), 16);
        step();
        check("ar_u0", 32'(dut_m.u_q[0]), 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
